// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer_chk.sv
// Protocol checker: a response must always have a drop slot or an unfilled entry.
module fetch_buffer_chk (
  input logic CLK,
  input logic reset,
  input logic rsp_valid_i,
  input logic drop_zero_i,
  input logic unfilled_zero_i
);
  // Flag responses that have no outstanding request to belong to.
  always @(posedge CLK) begin
    if (!reset) begin
      assert (!(rsp_valid_i && drop_zero_i && unfilled_zero_i));
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// Circular buffer of fetch entries, allocated at request time and filled by
// in-order responses; separate alloc, fill and pop pointers.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            pop_i,
  output logic [CW-1:0]   alloc_cnt_o,
  output logic [CW-1:0]   unfilled_o,
  output fetch_entry_t    head_o
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  ent_q [DEPTH];
  logic [PW-1:0] tail_q;
  logic [PW-1:0] fill_q;
  logic [PW-1:0] head_q;
  logic [CW-1:0] alloc_cnt_q;
  logic [CW-1:0] unfilled_q;

  // Entry storage, pointers and occupancy counters.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      tail_q      <= '0;
      fill_q      <= '0;
      head_q      <= '0;
      alloc_cnt_q <= '0;
      unfilled_q  <= '0;
    end else if (clear_i) begin
      // Stale entries need no scrubbing: allocation rewrites the filled flag.
      tail_q      <= '0;
      fill_q      <= '0;
      head_q      <= '0;
      alloc_cnt_q <= '0;
      unfilled_q  <= '0;
    end else begin
      if (alloc_i) begin
        ent_q[tail_q].pc     <= alloc_pc_i;
        ent_q[tail_q].filled <= 1'b0;
        tail_q               <= tail_q + PW'(1);
      end
      if (fill_i) begin
        ent_q[fill_q].instr  <= fill_data_i;
        ent_q[fill_q].filled <= 1'b1;
        fill_q               <= fill_q + PW'(1);
      end
      if (pop_i) begin
        head_q <= head_q + PW'(1);
      end
      alloc_cnt_q <= alloc_cnt_q + CW'(alloc_i) - CW'(pop_i);
      unfilled_q  <= unfilled_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  assign alloc_cnt_o = alloc_cnt_q;
  assign unfilled_o  = unfilled_q;
  assign head_o      = ent_q[head_q];
endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: issues imem requests for PCF, buffers in-order
// responses and drives the IF/ID register, dropping responses made stale by redirects.
module fetch_buffer #(
  parameter int                        DEPTH     = 2,
  parameter logic [fetch_pkg::XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic [fetch_pkg::XLEN-1:0]  PCF,
  input  logic                        PCSrcE,
  output logic                        pc_en,
  output logic                        imem_req_valid,
  output logic [fetch_pkg::XLEN-1:0]  imem_req_addr,
  input  logic                        imem_req_ready,
  input  logic                        imem_rsp_valid,
  input  logic [fetch_pkg::XLEN-1:0]  imem_rsp_data,
  input  logic                        StallD,
  input  logic                        FlushD,
  output logic [fetch_pkg::XLEN-1:0]  InstrD,
  output logic [fetch_pkg::XLEN-1:0]  PCD,
  output logic [fetch_pkg::XLEN-1:0]  PCPlus4D,
  output logic                        ValidD
);
  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   alloc_cnt_s;
  logic [CW-1:0]   unfilled_s;
  fetch_entry_t    head_s;
  logic [CW:0]     inflight_s;
  logic            issue_ok_s;
  logic            accept_s;
  logic            rsp_drop_s;
  logic            fill_s;
  logic            head_vld_s;
  logic            pop_s;
  logic [CW-1:0]   drop_cnt_q;
  logic [CW-1:0]   drop_cnt_d;
  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc4_q;

  // Registered counts only: a same-cycle pop does not free a slot for issue.
  assign inflight_s = {1'b0, alloc_cnt_s} + {1'b0, drop_cnt_q};
  assign issue_ok_s = !PCSrcE && (inflight_s < (CW+1)'(DEPTH));

  assign imem_req_valid = !reset && issue_ok_s;
  assign imem_req_addr  = PCF;
  assign accept_s       = imem_req_valid && imem_req_ready;
  assign pc_en          = !reset && (accept_s || PCSrcE);

  assign rsp_drop_s = imem_rsp_valid && (drop_cnt_q != '0);
  assign fill_s     = imem_rsp_valid && (drop_cnt_q == '0) && (unfilled_s != '0);
  assign head_vld_s = (alloc_cnt_s != '0) && head_s.filled;
  assign pop_s      = !PCSrcE && !FlushD && !StallD && head_vld_s;

  // On redirect every outstanding request becomes a drop, minus any response consumed now.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (PCSrcE) begin
      drop_cnt_d = drop_cnt_q + unfilled_s - CW'(rsp_drop_s || fill_s);
    end else if (rsp_drop_s) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_queue (
    .CLK         (CLK),
    .reset       (reset),
    .clear_i     (PCSrcE),
    .alloc_i     (accept_s),
    .alloc_pc_i  (PCF),
    .fill_i      (fill_s),
    .fill_data_i (imem_rsp_data),
    .pop_i       (pop_s),
    .alloc_cnt_o (alloc_cnt_s),
    .unfilled_o  (unfilled_s),
    .head_o      (head_s)
  );

  // Drop counter and IF/ID register with redirect > flush > stall > load priority.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc4_q      <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      if (PCSrcE || FlushD) begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end else if (StallD) begin
        valid_q <= valid_q;
        instr_q <= instr_q;
      end else if (head_vld_s) begin
        valid_q <= 1'b1;
        instr_q <= head_s.instr;
        pc_q    <= head_s.pc;
        pc4_q   <= head_s.pc + 32'd4;
      end else begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end
    end
  end

  assign ValidD   = valid_q;
  assign InstrD   = instr_q;
  assign PCD      = pc_q;
  assign PCPlus4D = pc4_q;

  fetch_buffer_chk u_chk (
    .CLK             (CLK),
    .reset           (reset),
    .rsp_valid_i     (imem_rsp_valid),
    .drop_zero_i     (drop_cnt_q == '0),
    .unfilled_zero_i (unfilled_s == '0)
  );
endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        PCSrcE;
  logic        pc_en;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        StallD;
  logic        FlushD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic [31:0] target;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .reset          (reset),
    .PCF            (PCF),
    .PCSrcE         (PCSrcE),
    .pc_en          (pc_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ment_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mrsp_t;

  ment_t       mq[$];
  int          m_drop;
  bit          m_valid;
  logic [31:0] m_instr, m_pc, m_pc4;

  mrsp_t mem_q[$];
  int    last_due, cyc, lat_min, lat_max;
  bit    rand_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop  = 0;
    m_valid = 1'b0;
    m_instr = NOP_INSTR;
    m_pc    = 32'h0;
    m_pc4   = 32'h0;
  endtask

  task automatic set_in(input bit rdy, input bit stl, input bit fl, input bit ps, input logic [31:0] tgt);
    imem_req_ready = rdy;
    StallD         = stl;
    FlushD         = fl;
    PCSrcE         = ps;
    target         = tgt;
  endtask

  // One clock: compare at negedge, advance model and environment, drive next inputs.
  task automatic step();
    bit          exp_rv, exp_en, exp_acc, head_ok;
    int          outstanding, due, lat;
    logic [31:0] next_pc, data;
    @(negedge CLK);
    exp_rv  = !PCSrcE && (mq.size() + m_drop < DEPTH);
    exp_acc = exp_rv && imem_req_ready;
    exp_en  = exp_acc || PCSrcE;
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check("pc_en",     32'(pc_en),          32'(exp_en));
    check("req_addr",  imem_req_addr,       PCF);
    check("ValidD",    32'(ValidD),         32'(m_valid));
    check("InstrD",    InstrD,              m_instr);
    check("PCD",       PCD,                 m_pc);
    check("PCPlus4D",  PCPlus4D,            m_pc4);

    if (imem_req_valid && imem_req_ready) begin
      lat  = $urandom_range(lat_max, lat_min);
      due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      data = rand_data ? $urandom : PCF;
      mem_q.push_back('{data: data, due: due});
      last_due = due;
    end
    next_pc = pc_en ? (PCSrcE ? target : PCF + 32'd4) : PCF;

    head_ok = (mq.size() > 0) && mq[0].filled;
    if (PCSrcE) begin
      outstanding = m_drop;
      foreach (mq[i]) if (!mq[i].filled) outstanding++;
      if (imem_rsp_valid) outstanding--;
      mq.delete();
      m_drop  = outstanding;
      m_valid = 1'b0;
      m_instr = NOP_INSTR;
    end else begin
      if (imem_rsp_valid) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].instr  = imem_rsp_data;
              mq[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (FlushD) begin
        m_valid = 1'b0;
        m_instr = NOP_INSTR;
      end else if (StallD) begin
        m_valid = m_valid;
      end else if (head_ok) begin
        m_valid = 1'b1;
        m_instr = mq[0].instr;
        m_pc    = mq[0].pc;
        m_pc4   = mq[0].pc + 32'd4;
        void'(mq.pop_front());
      end else begin
        m_valid = 1'b0;
        m_instr = NOP_INSTR;
      end
      if (exp_acc) mq.push_back('{pc: PCF, instr: 32'h0, filled: 1'b0});
    end

    @(posedge CLK);
    #1;
    cyc++;
    PCF = next_pc;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_ValidD",    32'(ValidD),         32'h0);
    check("rst_InstrD",    InstrD,              NOP_INSTR);
    check("rst_PCD",       PCD,                 32'h0);
    check("rst_PCPlus4D",  PCPlus4D,            32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_pc_en",     32'(pc_en),          32'h0);
    model_reset();
    mem_q.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    PCF            = 32'h0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge CLK);
    #1;
    cyc++;
    @(posedge CLK);
    #3;
    reset    = 1'b0;
    last_due = cyc;
    #1;
    check("rst_first_addr", imem_req_addr,       32'h0);
    check("rst_first_req",  32'(imem_req_valid), 32'h1);
  endtask

  initial begin
    bit          r;
    logic [31:0] t;
    reset          = 1'b1;
    PCF            = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc       = 0;
    last_due  = 0;
    lat_min   = 1;
    lat_max   = 1;
    rand_data = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("init_ValidD",   32'(ValidD),         32'h0);
    check("init_InstrD",   InstrD,              NOP_INSTR);
    check("init_PCD",      PCD,                 32'h0);
    check("init_req",      32'(imem_req_valid), 32'h0);
    reset = 1'b0;

    // Streaming with PC-as-data, 1-cycle memory.
    run(8);
    // Memory not ready: PC must hold.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    run(3);
    // Decode stall while responses flow; queue fills, then drains in order.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    run(4);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    run(6);
    // Redirect to 0x100 with two responses outstanding; their data is junk.
    lat_min = 3; lat_max = 3; rand_data = 1'b1;
    run(4);
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    step();
    lat_min = 1; lat_max = 1; rand_data = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    run(8);
    // Flush with a filled head at PC 0x20.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h20);
    step();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    run(3);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    run(5);
    // PC wrap at the top of the address space.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    run(5);
    // Async reset with entries outstanding and a drop pending.
    lat_min = 3; lat_max = 3;
    run(3);
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    async_reset();
    lat_min = 1; lat_max = 1;
    run(6);

    // Randomized traffic.
    lat_min = 1; lat_max = 4; rand_data = 1'b1;
    for (int k = 0; k < 500; k++) begin
      r = ($urandom_range(99, 0) < 5);
      t = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      set_in($urandom_range(3, 0) != 0, $urandom_range(4, 0) == 0,
             $urandom_range(9, 0) == 0, r, t);
      if ($urandom_range(199, 0) == 0) async_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
